// File: rtl/band_meter_pkg.sv
// Shared types and helpers for the band meter: band geometry, scan states,
// and the saturating subtract used by level and peak decay.
package band_meter_pkg;
    localparam int NUM_BANDS = 7;
    localparam int BAND_W    = 8;
    localparam int IDX_W     = 3;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;
    typedef logic [NUM_BANDS-1:0][BAND_W-1:0] bands_t;

    // 9-bit intermediate; a borrow means the result would go negative.
    function automatic logic [BAND_W-1:0] sat_sub(input logic [BAND_W-1:0] a,
                                                  input logic [BAND_W-1:0] b);
        logic [BAND_W:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        return diff[BAND_W] ? '0 : diff[BAND_W-1:0];
    endfunction
endpackage

// File: rtl/band_tracker.sv
// Combinational next-state for one band: instant-attack level with decay,
// and a peak marker with hold time, decay and a floor at the level.
module band_tracker
    import band_meter_pkg::*;
#(
    parameter int DECAY_STEP   = 1,
    parameter int HOLD_SAMPLES = 24000,
    parameter int H_W          = 15
) (
    input  logic [BAND_W-1:0] x_i,
    input  logic [BAND_W-1:0] l_i,
    input  logic [BAND_W-1:0] p_i,
    input  logic [H_W-1:0]    h_i,
    input  logic              tick_i,
    output logic [BAND_W-1:0] l_o,
    output logic [BAND_W-1:0] p_o,
    output logic [H_W-1:0]    h_o
);
    localparam logic [BAND_W-1:0] STEP = BAND_W'(DECAY_STEP);
    localparam logic [H_W-1:0]    HOLD = H_W'(HOLD_SAMPLES);

    logic [BAND_W-1:0] p_t;

    always_comb begin
        l_o = l_i;
        p_t = p_i;
        h_o = h_i;

        if (x_i > l_i)   l_o = x_i;
        else if (tick_i) l_o = sat_sub(l_i, STEP);

        if (x_i >= p_i) begin
            p_t = x_i;
            h_o = HOLD;
        end else if (h_i != '0) begin
            h_o = h_i - 1'b1;
        end else if (tick_i) begin
            p_t = sat_sub(p_i, STEP);
        end

        p_o = (p_t > l_o) ? p_t : l_o;
    end
endmodule

// File: rtl/band_meter.sv
// Seven-band level/peak meter: one shared band_tracker is walked across the
// bands by a scan FSM, one band per clock, with a one-deep pending snapshot.
module band_meter
    import band_meter_pkg::*;
#(
    parameter int DECAY_DIV    = 256,
    parameter int DECAY_STEP   = 1,
    parameter int HOLD_SAMPLES = 24000
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        ready_i,
    input  logic [BAND_W-1:0]           freq1_i,
    input  logic [BAND_W-1:0]           freq2_i,
    input  logic [BAND_W-1:0]           freq3_i,
    input  logic [BAND_W-1:0]           freq4_i,
    input  logic [BAND_W-1:0]           freq5_i,
    input  logic [BAND_W-1:0]           freq6_i,
    input  logic [BAND_W-1:0]           freq7_i,
    output logic [NUM_BANDS*BAND_W-1:0] levels_o,
    output logic [NUM_BANDS*BAND_W-1:0] peaks_o,
    output logic                        update_done_o,
    output logic                        overrun_o
);
    localparam int CNT_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam int H_W   = (HOLD_SAMPLES > 0) ? $clog2(HOLD_SAMPLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECAY_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BANDS - 1);

    bands_t freq_in;
    assign freq_in = {freq7_i, freq6_i, freq5_i, freq4_i, freq3_i, freq2_i, freq1_i};

    state_e                       state_q, state_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    bands_t                       snap_q, snap_d, pend_snap_q, pend_snap_d;
    bands_t                       lvl_q, lvl_d, pk_q, pk_d;
    logic [NUM_BANDS-1:0][H_W-1:0] hold_q, hold_d;
    logic                         pend_q, pend_d, tick_q, tick_d;
    logic                         ovr_q, ovr_d, done_q, done_d;

    logic                         start;
    bands_t                       start_snap;
    logic [BAND_W-1:0]            l_nx, p_nx;
    logic [H_W-1:0]               h_nx;

    band_tracker #(
        .DECAY_STEP  (DECAY_STEP),
        .HOLD_SAMPLES(HOLD_SAMPLES),
        .H_W         (H_W)
    ) u_trk (
        .x_i   (snap_q[idx_q]),
        .l_i   (lvl_q[idx_q]),
        .p_i   (pk_q[idx_q]),
        .h_i   (hold_q[idx_q]),
        .tick_i(tick_q),
        .l_o   (l_nx),
        .p_o   (p_nx),
        .h_o   (h_nx)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        snap_d      = snap_q;
        pend_snap_d = pend_snap_q;
        lvl_d       = lvl_q;
        pk_d        = pk_q;
        hold_d      = hold_q;
        pend_d      = pend_q;
        tick_d      = tick_q;
        ovr_d       = ovr_q;
        done_d      = 1'b0;
        start       = 1'b0;
        start_snap  = freq_in;

        case (state_q)
            IDLE: begin
                if (ready_i) start = 1'b1;
            end
            SCAN: begin
                lvl_d[idx_q]  = l_nx;
                pk_d[idx_q]   = p_nx;
                hold_d[idx_q] = h_nx;
                if (ready_i) begin
                    if (!pend_q) begin
                        pend_snap_d = freq_in;
                        pend_d      = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end
                if (idx_q == IDX_LAST) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                // A strobe landing here with nothing pending starts straight
                // away, so 8-cycle spacing never loses a sample.
                if (pend_q) begin
                    start      = 1'b1;
                    start_snap = pend_snap_q;
                    pend_d     = 1'b0;
                    if (ready_i) ovr_d = 1'b1;
                end else if (ready_i) begin
                    start = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            snap_d  = start_snap;
            tick_d  = (cnt_q == CNT_LAST);
            cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
            idx_d   = '0;
            state_d = SCAN;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            snap_q      <= '0;
            pend_snap_q <= '0;
            lvl_q       <= '0;
            pk_q        <= '0;
            hold_q      <= '0;
            pend_q      <= 1'b0;
            tick_q      <= 1'b0;
            ovr_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            snap_q      <= snap_d;
            pend_snap_q <= pend_snap_d;
            lvl_q       <= lvl_d;
            pk_q        <= pk_d;
            hold_q      <= hold_d;
            pend_q      <= pend_d;
            tick_q      <= tick_d;
            ovr_q       <= ovr_d;
            done_q      <= done_d;
        end
    end

    assign levels_o      = lvl_q;
    assign peaks_o       = pk_q;
    assign update_done_o = done_q;
    assign overrun_o     = ovr_q;
endmodule

// File: tb/tb_band_meter.sv
// Directed bench for band_meter with DECAY_DIV=4, DECAY_STEP=2, HOLD_SAMPLES=3;
// expected frames are queued at stimulus time and checked on update_done.
module tb_band_meter;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ready = 1'b0;
    logic [7:0]  fr [7];
    logic [55:0] levels, peaks;
    logic        update_done, overrun;

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          cyc;
        logic [55:0] lv;
        logic [55:0] pk;
        string       tag;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    band_meter #(.DECAY_DIV(4), .DECAY_STEP(2), .HOLD_SAMPLES(3)) dut (
        .clock        (clock),
        .reset        (reset),
        .ready_i      (ready),
        .freq1_i      (fr[0]),
        .freq2_i      (fr[1]),
        .freq3_i      (fr[2]),
        .freq4_i      (fr[3]),
        .freq5_i      (fr[4]),
        .freq6_i      (fr[5]),
        .freq7_i      (fr[6]),
        .levels_o     (levels),
        .peaks_o      (peaks),
        .update_done_o(update_done),
        .overrun_o    (overrun)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [55:0] all_b(input logic [7:0] v);
        logic [55:0] r;
        for (int i = 0; i < 7; i++) r[8*i +: 8] = v;
        return r;
    endfunction

    function automatic logic [55:0] set_b(input logic [55:0] vv, input int i, input int v);
        logic [55:0] r;
        r = vv;
        r[8*i +: 8] = 8'(v);
        return r;
    endfunction

    task automatic set_fr_all(input logic [7:0] v);
        for (int i = 0; i < 7; i++) fr[i] = v;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        ready = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Returns the cycle stamp of the edge that sampled the strobe.
    task automatic pulse(output int e0);
        @(negedge clock);
        ready = 1'b1;
        @(negedge clock);
        ready = 1'b0;
        e0 = cyc;
    endtask

    task automatic send(input logic [55:0] lv, input logic [55:0] pk, input string tag);
        int e0;
        pulse(e0);
        sb.push_back('{e0 + 7, lv, pk, tag});
        repeat (9) @(negedge clock);
    endtask

    always @(negedge clock) begin
        if (update_done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got update_done=1 at cycle %0d expected none", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.tag, "_cycle"},  cyc,    mon_e.cyc);
                chk({mon_e.tag, "_levels"}, levels, mon_e.lv);
                chk({mon_e.tag, "_peaks"},  peaks,  mon_e.pk);
            end
        end
    end

    int l3 [12] = '{200, 200, 200, 198, 198, 198, 198, 196, 196, 196, 196, 194};
    int p3 [12] = '{200, 200, 200, 200, 200, 200, 200, 198, 198, 198, 198, 196};
    int x5a[8] = '{40, 0, 0, 0, 0, 40, 0, 0};
    int x5b[8] = '{30, 0, 0, 0, 28, 0, 0, 0};
    int l5a[8] = '{40, 40, 40, 38, 38, 40, 40, 38};
    int p5a[8] = '{40, 40, 40, 40, 40, 40, 40, 40};
    int l5b[8] = '{30, 30, 30, 28, 28, 28, 28, 26};
    int p5b[8] = '{30, 30, 30, 30, 30, 30, 30, 28};

    initial begin
        logic [55:0] lv, pk;
        int e0, k, l, p;

        set_fr_all(8'd0);
        repeat (3) @(negedge clock);
        chk("rst_levels", levels, 0);
        chk("rst_peaks", peaks, 0);
        chk("rst_done", update_done, 0);
        chk("rst_overrun", overrun, 0);
        reset = 1'b0;

        // First sample after reset: everything attacks to the input.
        lv = '0;
        for (int i = 0; i < 7; i++) begin
            fr[i] = 8'(10 * (i + 1));
            lv = set_b(lv, i, 10 * (i + 1));
        end
        send(lv, lv, "first");

        // Level attack then linear decay to a floor of zero on band1.
        do_reset();
        set_fr_all(8'd0);
        fr[0] = 8'd100;
        for (int n = 1; n <= 204; n++) begin
            if (n == 2) fr[0] = 8'd0;
            k = n / 4;
            l = 100 - 2 * k;
            if (l < 0) l = 0;
            p = 102 - 2 * k;
            if (p > 100) p = 100;
            if (p < 0) p = 0;
            send(set_b(all_b(0), 0, l), set_b(all_b(0), 0, p), $sformatf("decay%0d", n));
        end

        // Peak hold on band2.
        do_reset();
        set_fr_all(8'd0);
        for (int n = 0; n < 12; n++) begin
            fr[1] = (n == 0) ? 8'd200 : 8'd50;
            send(set_b(all_b(0), 1, l3[n]), set_b(all_b(0), 1, p3[n]), $sformatf("hold%0d", n + 1));
        end

        // Back-to-back: second strobe goes pending, third is dropped.
        do_reset();
        set_fr_all(8'd5);
        pulse(e0);
        sb.push_back('{e0 + 7,  all_b(5), all_b(5), "b2b_a"});
        sb.push_back('{e0 + 15, all_b(9), all_b(9), "b2b_b"});
        set_fr_all(8'd9);
        ready = 1'b1;
        @(negedge clock);
        ready = 1'b0;
        chk("b2b_ovr_pending", overrun, 0);
        set_fr_all(8'd30);
        ready = 1'b1;
        @(negedge clock);
        ready = 1'b0;
        chk("b2b_ovr_drop", overrun, 1);
        repeat (14) @(negedge clock);
        set_fr_all(8'd0);
        send(all_b(9), all_b(9), "b2b_after_drop");
        chk("b2b_ovr_sticky", overrun, 1);

        // Strobes exactly 8 cycles apart: second starts from DONE directly.
        do_reset();
        set_fr_all(8'd7);
        pulse(e0);
        sb.push_back('{e0 + 7,  all_b(7), all_b(7), "min_x"});
        sb.push_back('{e0 + 15, all_b(7), all_b(7), "min_y"});
        repeat (7) @(negedge clock);
        set_fr_all(8'd3);
        ready = 1'b1;
        @(negedge clock);
        ready = 1'b0;
        repeat (12) @(negedge clock);
        chk("min_overrun", overrun, 0);

        // Equality against peak (band3) and against level (band4).
        do_reset();
        set_fr_all(8'd0);
        for (int n = 0; n < 8; n++) begin
            fr[2] = 8'(x5a[n]);
            fr[3] = 8'(x5b[n]);
            lv = set_b(set_b(all_b(0), 2, l5a[n]), 3, l5b[n]);
            pk = set_b(set_b(all_b(0), 2, p5a[n]), 3, p5b[n]);
            send(lv, pk, $sformatf("eq%0d", n + 1));
        end

        // Reset mid-scan together with a strobe.
        do_reset();
        set_fr_all(8'd50);
        pulse(e0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        ready = 1'b1;
        set_fr_all(8'd99);
        @(negedge clock);
        chk("midrst_levels", levels, 0);
        chk("midrst_peaks", peaks, 0);
        chk("midrst_done", update_done, 0);
        chk("midrst_overrun", overrun, 0);
        reset = 1'b0;
        ready = 1'b0;
        repeat (12) @(negedge clock);
        set_fr_all(8'd11);
        send(all_b(11), all_b(11), "after_midrst");

        repeat (4) @(negedge clock);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
